// File: rtl/ram_fib_seq_ctrl_if.sv
// Single-port synchronous RAM pins as seen by the sequencer (master) and the memory (slave).
// mem_rdata is valid the cycle after an address is presented with mem_we low.
interface ram_fib_seq_ctrl_if #(
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned DATA_W = 32
);
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport master (output mem_we, mem_addr, mem_wdata, input  mem_rdata);
   modport slave  (input  mem_we, mem_addr, mem_wdata, output mem_rdata);
endinterface

// File: rtl/ram_fib_seq_ctrl.sv
// Fills a single-port RAM with N Fibonacci-style words: seeds at 0/1, then word i = word(i-2) + word(i-1).
// Final write lands 2+4*(N-2) cycles after start is accepted; no backpressure, the RAM takes one access per cycle.
module ram_fib_seq_ctrl #(
   parameter int unsigned       ADDR_W = 6,
   parameter int unsigned       DATA_W = 32,
   parameter int unsigned       N      = 64,
   parameter logic [DATA_W-1:0] SEED0  = DATA_W'(1),
   parameter logic [DATA_W-1:0] SEED1  = DATA_W'(1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   ram_fib_seq_ctrl_if.master mem,
   output logic               busy,
   output logic               done,
   output logic [DATA_W-1:0]  last_value
);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

   typedef enum logic [2:0] {IDLE, W0, W1, RD_A, RD_B, CAP, WR, DONE} state_t;

   state_t            state;
   logic [ADDR_W-1:0] index;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;

   // RAM pins are registered: each branch loads the values belonging to the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         index         <= '0;
         a             <= '0;
         b             <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         last_value    <= '0;
         mem.mem_we    <= 1'b0;
         mem.mem_addr  <= '0;
         mem.mem_wdata <= '0;
      end else begin
         mem.mem_we    <= 1'b0;
         mem.mem_addr  <= '0;
         mem.mem_wdata <= '0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state         <= W0;
                  done          <= 1'b0;
                  busy          <= 1'b1;
                  mem.mem_we    <= 1'b1;
                  mem.mem_wdata <= SEED0;
               end
            end
            W0: begin
               last_value    <= SEED0;
               state         <= W1;
               mem.mem_we    <= 1'b1;
               mem.mem_addr  <= ADDR_W'(1);
               mem.mem_wdata <= SEED1;
            end
            W1: begin
               last_value <= SEED1;
               index      <= ADDR_W'(2);
               state      <= RD_A;
            end
            RD_A: begin
               state        <= RD_B;
               mem.mem_addr <= index - ADDR_W'(1);
            end
            RD_B: begin
               a     <= mem.mem_rdata;
               state <= CAP;
            end
            CAP: begin
               // b is still loading this edge, so the sum takes the fresh read word directly.
               b             <= mem.mem_rdata;
               state         <= WR;
               mem.mem_we    <= 1'b1;
               mem.mem_addr  <= index;
               mem.mem_wdata <= a + mem.mem_rdata;
            end
            WR: begin
               last_value <= a + b;
               if (index == LAST_IDX) begin
                  state <= DONE;
               end else begin
                  index        <= index + ADDR_W'(1);
                  state        <= RD_A;
                  mem.mem_addr <= index - ADDR_W'(1);
               end
            end
            DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ram_fib_seq_ctrl.sv
// Directed bench for ram_fib_seq_ctrl: three instances (N=8/32b seeds 1,1; N=16/8b; N=8 seeds 2,3) with behavioural RAMs.
// Expected writes are queued when a run is started and popped as the DUT writes.
module tb_ram_fib_seq_ctrl;
   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } sb_t;

   logic clk     = 1'b0;
   logic rst     = 1'b1;
   logic start_a = 1'b0;
   logic start_b = 1'b0;
   logic start_c = 1'b0;

   logic        busy_a, done_a, busy_b, done_b, busy_c, done_c;
   logic [31:0] lv_a, lv_c;
   logic [7:0]  lv_b;

   logic [31:0] ram_a [8];
   logic [7:0]  ram_b [16];
   logic [31:0] ram_c [8];

   logic [31:0] exp_a  [8] = '{32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8, 32'd13, 32'd21};
   logic [31:0] exp_c  [8] = '{32'd2, 32'd3, 32'd5, 32'd8, 32'd13, 32'd21, 32'd34, 32'd55};
   logic [31:0] exp_b4 [4] = '{32'd233, 32'd121, 32'd98, 32'd219};

   sb_t q[$];
   sb_t ea, eb, ec;
   int  checks = 0;
   int  passed = 0;

   always #5 clk = ~clk;

   ram_fib_seq_ctrl_if #(.ADDR_W(3), .DATA_W(32)) ia ();
   ram_fib_seq_ctrl_if #(.ADDR_W(4), .DATA_W(8))  ib ();
   ram_fib_seq_ctrl_if #(.ADDR_W(3), .DATA_W(32)) ic ();

   ram_fib_seq_ctrl #(.ADDR_W(3), .DATA_W(32), .N(8)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .mem(ia),
      .busy(busy_a), .done(done_a), .last_value(lv_a));

   ram_fib_seq_ctrl #(.ADDR_W(4), .DATA_W(8), .N(16)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .mem(ib),
      .busy(busy_b), .done(done_b), .last_value(lv_b));

   ram_fib_seq_ctrl #(.ADDR_W(3), .DATA_W(32), .N(8), .SEED0(32'd2), .SEED1(32'd3)) dut_c (
      .clk(clk), .rst(rst), .start(start_c), .mem(ic),
      .busy(busy_c), .done(done_c), .last_value(lv_c));

   always @(posedge clk) begin
      if (ia.mem_we) ram_a[ia.mem_addr] <= ia.mem_wdata;
      ia.mem_rdata <= ram_a[ia.mem_addr];
      if (ib.mem_we) ram_b[ib.mem_addr] <= ib.mem_wdata;
      ib.mem_rdata <= ram_b[ib.mem_addr];
      if (ic.mem_we) ram_c[ic.mem_addr] <= ic.mem_wdata;
      ic.mem_rdata <= ram_c[ic.mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   always @(negedge clk) begin
      if (!rst && ia.mem_we) begin
         chk("a_sb_nonempty", 32'(q.size() != 0), 32'd1);
         if (q.size() != 0) begin
            ea = q.pop_front();
            chk("a_wr_addr", 32'(ia.mem_addr), ea.addr);
            chk("a_wr_data", ia.mem_wdata, ea.data);
         end
      end
      if (!rst && ib.mem_we) begin
         chk("b_sb_nonempty", 32'(q.size() != 0), 32'd1);
         if (q.size() != 0) begin
            eb = q.pop_front();
            chk("b_wr_addr", 32'(ib.mem_addr), eb.addr);
            chk("b_wr_data", 32'(ib.mem_wdata), eb.data);
         end
      end
      if (!rst && ic.mem_we) begin
         chk("c_sb_nonempty", 32'(q.size() != 0), 32'd1);
         if (q.size() != 0) begin
            ec = q.pop_front();
            chk("c_wr_addr", 32'(ic.mem_addr), ec.addr);
            chk("c_wr_data", ic.mem_wdata, ec.data);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_fib(input int n, input logic [31:0] s0, input logic [31:0] s1, input int dw);
      logic [31:0] mask, x0, x1, x2;
      mask = (dw >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << dw) - 64'd1);
      x0 = s0 & mask;
      x1 = s1 & mask;
      q.push_back('{addr: 32'd0, data: x0});
      q.push_back('{addr: 32'd1, data: x1});
      for (int i = 2; i < n; i++) begin
         x2 = (x0 + x1) & mask;
         q.push_back('{addr: 32'(i), data: x2});
         x0 = x1;
         x1 = x2;
      end
   endtask

   task automatic wait_done(input int sel, input int budget);
      int k = 0;
      while (!((sel == 1) ? done_b : done_c) && k < budget) begin
         step();
         k++;
      end
      chk("wait_done", 32'((sel == 1) ? done_b : done_c), 32'd1);
   endtask

   // After start is accepted, each loop pass observes cycle c (W0 = cycle 1, final WR = cycle 26).
   task automatic run_a(input bit repulse, input bit do_reset);
      int n_busy = 0;
      push_fib(8, 32'd1, 32'd1, 32);
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      chk("a_done_cleared", 32'(done_a), 32'd0);
      for (int c = 1; c <= 26; c++) begin
         if (do_reset && c == 12) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
            chk("rst_busy", 32'(busy_a), 32'd0);
            chk("rst_done", 32'(done_a), 32'd0);
            chk("rst_we", 32'(ia.mem_we), 32'd0);
            chk("rst_last_value", lv_a, 32'd0);
            q.delete();
            return;
         end
         start_a = repulse && (c == 5 || c == 20);
         if (busy_a) n_busy++;
         if (c == 26) begin
            chk("a_final_we", 32'(ia.mem_we), 32'd1);
            chk("a_final_addr", 32'(ia.mem_addr), 32'd7);
         end
         step();
      end
      start_a = 1'b0;
      chk("a_busy_cycles", 32'(n_busy), 32'd26);
      chk("a_done_early", 32'(done_a), 32'd0);
      step();
      chk("a_done_rise", 32'(done_a), 32'd1);
      chk("a_busy_fall", 32'(busy_a), 32'd0);
      repeat (3) step();
      chk("a_done_held", 32'(done_a), 32'd1);
      chk("a_last_value", lv_a, 32'd21);
      for (int i = 0; i < 8; i++) chk($sformatf("a_ram%0d", i), ram_a[i], exp_a[i]);
      chk("a_sb_drained", 32'(q.size()), 32'd0);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) step();
      chk("reset_busy", 32'(busy_a), 32'd0);
      chk("reset_done", 32'(done_a), 32'd0);
      chk("reset_we", 32'(ia.mem_we), 32'd0);
      chk("reset_addr", 32'(ia.mem_addr), 32'd0);
      chk("reset_wdata", ia.mem_wdata, 32'd0);
      chk("reset_last_value", lv_a, 32'd0);
      rst = 1'b0;
      step();

      run_a(1'b0, 1'b0);
      run_a(1'b1, 1'b0);
      run_a(1'b0, 1'b1);
      step();
      run_a(1'b0, 1'b0);

      push_fib(16, 32'd1, 32'd1, 8);
      start_b = 1'b1;
      step();
      start_b = 1'b0;
      wait_done(1, 200);
      chk("b_last_value", 32'(lv_b), 32'd219);
      for (int i = 0; i < 4; i++) chk($sformatf("b_ram%0d", 12 + i), 32'(ram_b[12 + i]), exp_b4[i]);
      chk("b_sb_drained", 32'(q.size()), 32'd0);

      push_fib(8, 32'd2, 32'd3, 32);
      start_c = 1'b1;
      step();
      start_c = 1'b0;
      for (int c = 1; c <= 26; c++) step();
      start_c = 1'b1;
      step();
      start_c = 1'b0;
      chk("c_done_rise", 32'(done_c), 32'd1);
      chk("c_start_in_done_ignored", 32'(busy_c), 32'd0);
      chk("c_idle_we", 32'(ic.mem_we), 32'd0);
      step();
      chk("c_done_hold", 32'(done_c), 32'd1);
      chk("c_still_idle", 32'(busy_c), 32'd0);
      chk("c_sb_drained1", 32'(q.size()), 32'd0);

      push_fib(8, 32'd2, 32'd3, 32);
      start_c = 1'b1;
      step();
      start_c = 1'b0;
      chk("c_done_drop", 32'(done_c), 32'd0);
      chk("c_busy_rise", 32'(busy_c), 32'd1);
      wait_done(2, 200);
      chk("c_last_value", lv_c, 32'd55);
      for (int i = 0; i < 8; i++) chk($sformatf("c_ram%0d", i), ram_c[i], exp_c[i]);
      chk("c_sb_drained2", 32'(q.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
